// File: rtl/tt_logic_pkg.sv
// Shared types and helpers for the truth-table logic engine.
package tt_logic_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_shift_loader.sv
// Serial truth-table loader: shadow shift register, bit counter and optional parity check.
// Optional feature macro: TT_LOGIC_ENGINE_PARITY_EN (expects a trailing even-parity bit).
module tt_shift_loader
  import tt_logic_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        active,
  input  logic                        cfg_valid,
  input  logic                        cfg_bit,
  output logic [tt_width(N_IN)-1:0]   shadow,
  output logic                        done,
  output logic                        commit,
  output logic                        err
);

  localparam int W = tt_width(N_IN);
  localparam logic [N_IN:0] W_CNT = (N_IN+1)'(W);
`ifdef TT_LOGIC_ENGINE_PARITY_EN
  localparam logic [N_IN:0] LAST = (N_IN+1)'(W);
`else
  localparam logic [N_IN:0] LAST = (N_IN+1)'(W - 1);
`endif

  logic [N_IN:0] cnt;
  logic          take;
  logic          last;
  logic          table_bit;
  logic          ok;

  // The counter parks one past LAST, so stray strobes during the done cycle are ignored.
  assign take      = active && cfg_valid && (cnt <= LAST);
  assign last      = take && (cnt == LAST);
  assign table_bit = take && (cnt < W_CNT);

`ifdef TT_LOGIC_ENGINE_PARITY_EN
  logic par;
  logic err_q;

  assign ok  = (cfg_bit == par);
  assign err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par   <= 1'b0;
      err_q <= 1'b0;
    end else if (start) begin
      par   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (table_bit) par <= par ^ cfg_bit;
      if (last && !ok) err_q <= 1'b1;
    end
  end
`else
  assign ok  = 1'b1;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      shadow <= '0;
      done   <= 1'b0;
      commit <= 1'b0;
    end else begin
      done   <= last;
      commit <= last && ok;
      if (start) begin
        cnt    <= '0;
        shadow <= '0;
      end else begin
        if (take) cnt <= cnt + 1'b1;
        // Right shift so the first bit received lands at table index 0.
        if (table_bit) shadow <= {cfg_bit, shadow[W-1:1]};
      end
    end
  end

endmodule

// File: rtl/tt_logic_engine.sv
// Truth-table logic engine: evaluates in_vec against a reloadable table with a valid/ready output stage.
// Optional feature macro: TT_LOGIC_ENGINE_PARITY_EN (parity-checked table loads, see tt_shift_loader).
module tt_logic_engine
  import tt_logic_pkg::*;
#(
  parameter int                        N_IN       = 4,
  parameter logic [tt_width(N_IN)-1:0] TT_DEFAULT = 16'h0760
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_done,
  output logic            cfg_err,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic            busy
);

  localparam int W = tt_width(N_IN);

  state_t         state;
  logic [W-1:0]   tt_q;
  logic [W-1:0]   shadow;
  logic           commit;
  logic           load_start;
  logic           accept;

  assign in_ready   = (state == RUN) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign load_start = cfg_start && (state == RUN);

  tt_shift_loader #(.N_IN(N_IN)) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (load_start),
    .active    (state == LOAD),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .shadow    (shadow),
    .done      (cfg_done),
    .commit    (commit),
    .err       (cfg_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      busy      <= 1'b0;
      tt_q      <= TT_DEFAULT;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else begin
      case (state)
        RUN: if (cfg_start) begin
          state <= LOAD;
          busy  <= 1'b1;
        end
        LOAD: if (cfg_done) begin
          state <= RUN;
          busy  <= 1'b0;
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
      if (commit) tt_q <= shadow;
      // An accept coinciding with cfg_start still sees the old table.
      if (accept) begin
        out_valid <= 1'b1;
        out_bit   <= tt_q[in_vec];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tt_logic_engine.sv
// Directed self-checking bench for tt_logic_engine with N_IN=4 and the default table 16'h0760.
module tb_tt_logic_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       cfg_done;
  logic       cfg_err;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_vec = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_bit;
  logic       busy;

  int n_chk = 0;
  int n_pass = 0;

`ifdef TT_LOGIC_ENGINE_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  tt_logic_engine #(.N_IN(4), .TT_DEFAULT(16'h0760)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic eval_vec(input logic [3:0] v, output logic b, output logic ov);
    in_vec    = v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    b  = out_bit;
    ov = out_valid;
    in_valid = 1'b0;
  endtask

  // Streams n bits (LSB first) with a one-cycle gap between strobes; no gap after the last bit.
  task automatic send_bits(input logic [16:0] bits, input int n,
                           output int done_cnt, output int done_at, output int ready_hi);
    done_cnt = 0;
    done_at  = -1;
    ready_hi = 0;
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = bits[i];
      tick();
      if (cfg_done) begin done_cnt++; done_at = i; end
      if (in_ready) ready_hi++;
      cfg_valid = 1'b0;
      if (i < n - 1) begin
        tick();
        if (cfg_done) done_cnt++;
        if (in_ready) ready_hi++;
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else n_pass++;
    n_chk++; if ({out_valid, out_bit, busy, cfg_done, cfg_err} !== 5'b0)
      $display("FAIL rst_outputs got %b want 00000", {out_valid, out_bit, busy, cfg_done, cfg_err}); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_chk++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 4'd5;
    tick();
    n_chk++; if ({out_valid, out_bit} !== 2'b11) $display("FAIL b2b_vec5 got v%b b%b want v1 b1", out_valid, out_bit); else n_pass++;
    in_vec = 4'd4;
    tick();
    n_chk++; if ({out_valid, out_bit} !== 2'b10) $display("FAIL b2b_vec4 got v%b b%b want v1 b0", out_valid, out_bit); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 4'd9;
    tick();
    in_vec = 4'd4;
    for (int c = 0; c < 3; c++) begin
      n_chk++; if ({out_valid, out_bit, in_ready} !== 3'b110)
        $display("FAIL bp_hold%0d got v%b b%b r%b want v1 b1 r0", c, out_valid, out_bit, in_ready); else n_pass++;
      if (c < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready); else n_pass++;
    tick();
    n_chk++; if ({out_valid, out_bit} !== 2'b10) $display("FAIL bp_next_vec4 got v%b b%b want v1 b0", out_valid, out_bit); else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_cfg_with_accept();
    int   dc, da, rh;
    logic b, ov;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 4'd6;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    n_chk++; if ({out_valid, out_bit, busy, in_ready} !== 4'b1110)
      $display("FAIL cfgacc_old_table got v%b b%b busy%b r%b want v1 b1 busy1 r0", out_valid, out_bit, busy, in_ready); else n_pass++;
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL cfgacc_drain got %b want 0", out_valid); else n_pass++;
    send_bits(17'h00000, NB, dc, da, rh);
    n_chk++; if (rh !== 0) $display("FAIL cfgacc_ready_in_load got %0d want 0", rh); else n_pass++;
    n_chk++; if (dc !== 1 || da !== NB - 1) $display("FAIL cfgacc_done got cnt%0d at%0d want cnt1 at%0d", dc, da, NB - 1); else n_pass++;
    tick();
    n_chk++; if ({busy, in_ready} !== 2'b01) $display("FAIL cfgacc_back_run got busy%b r%b want busy0 r1", busy, in_ready); else n_pass++;
    eval_vec(4'd6, b, ov);
    n_chk++; if ({ov, b} !== 2'b10) $display("FAIL cfgacc_new_table got v%b b%b want v1 b0", ov, b); else n_pass++;
    tick();
  endtask

  task automatic test_load();
    int          dc, da, rh;
    logic        b, ov;
    logic [16:0] bits;
    bits = {^16'h8001, 16'h8001};
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    n_chk++; if ({busy, in_ready, cfg_done} !== 3'b100) $display("FAIL load_enter got busy%b r%b d%b want busy1 r0 d0", busy, in_ready, cfg_done); else n_pass++;
    send_bits(bits, NB, dc, da, rh);
    n_chk++; if (dc !== 1 || da !== NB - 1) $display("FAIL load_done got cnt%0d at%0d want cnt1 at%0d", dc, da, NB - 1); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL load_busy_done_cycle got %b want 1", busy); else n_pass++;
    tick();
    n_chk++; if ({busy, cfg_done, cfg_err} !== 3'b000) $display("FAIL load_exit got busy%b d%b e%b want 000", busy, cfg_done, cfg_err); else n_pass++;
    eval_vec(4'd15, b, ov);
    n_chk++; if ({ov, b} !== 2'b11) $display("FAIL load_vec15 got v%b b%b want v1 b1", ov, b); else n_pass++;
    eval_vec(4'd5, b, ov);
    n_chk++; if ({ov, b} !== 2'b10) $display("FAIL load_vec5 got v%b b%b want v1 b0", ov, b); else n_pass++;
    eval_vec(4'd0, b, ov);
    n_chk++; if ({ov, b} !== 2'b11) $display("FAIL load_vec0 got v%b b%b want v1 b1", ov, b); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_load();
    int   dc, da, rh;
    int   late_done;
    logic b, ov;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    send_bits(17'h1FFFF, 7, dc, da, rh);
    n_chk++; if (dc !== 0) $display("FAIL midrst_early_done got %0d want 0", dc); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({busy, cfg_done, in_ready} !== 3'b001) $display("FAIL midrst_in_reset got busy%b d%b r%b want busy0 d0 r1", busy, cfg_done, in_ready); else n_pass++;
    tick();
    rst_n = 1'b1;
    late_done = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (cfg_done) late_done++;
    end
    n_chk++; if (late_done !== 0) $display("FAIL midrst_no_done got %0d want 0", late_done); else n_pass++;
    eval_vec(4'd8, b, ov);
    n_chk++; if ({ov, b} !== 2'b11) $display("FAIL midrst_vec8 got v%b b%b want v1 b1", ov, b); else n_pass++;
    eval_vec(4'd0, b, ov);
    n_chk++; if ({ov, b} !== 2'b10) $display("FAIL midrst_vec0 got v%b b%b want v1 b0", ov, b); else n_pass++;
    tick();
  endtask

`ifdef TT_LOGIC_ENGINE_PARITY_EN
  task automatic test_parity();
    int   dc, da, rh;
    logic b, ov;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    send_bits({1'b0, 16'h0001}, 17, dc, da, rh);
    n_chk++; if (dc !== 1 || da !== 16) $display("FAIL par_done got cnt%0d at%0d want cnt1 at16", dc, da); else n_pass++;
    n_chk++; if (cfg_err !== 1'b1) $display("FAIL par_err got %b want 1", cfg_err); else n_pass++;
    tick();
    eval_vec(4'd8, b, ov);
    n_chk++; if ({ov, b} !== 2'b11) $display("FAIL par_keep_vec8 got v%b b%b want v1 b1", ov, b); else n_pass++;
    eval_vec(4'd0, b, ov);
    n_chk++; if ({ov, b, cfg_err} !== 3'b101) $display("FAIL par_keep_vec0 got v%b b%b e%b want v1 b0 e1", ov, b, cfg_err); else n_pass++;
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    n_chk++; if (cfg_err !== 1'b0) $display("FAIL par_err_clear got %b want 0", cfg_err); else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_cfg_with_accept();
    test_load();
    test_reset_mid_load();
`ifdef TT_LOGIC_ENGINE_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tt_logic_engine.md
TT_LOGIC_ENGINE -- requirements
Module: tt_logic_engine

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, giving the number of logic inputs (1..8).
REQ-002 The block SHALL have parameter TT_DEFAULT, 2**N_IN bits wide, default 16'h0760, giving the truth table loaded at reset.
REQ-003 Port clk, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port cfg_start, input, 1: request to reload the truth table.
REQ-006 Ports cfg_valid and cfg_bit, input, 1 each: serial table-load strobe and data.
REQ-007 Port cfg_done, output, 1: single-cycle pulse when a load ends.
REQ-008 Port cfg_err, output, 1: sticky load-error flag.
REQ-009 Ports in_valid (input, 1), in_ready (output, 1) and in_vec (input, N_IN): evaluation request handshake.
REQ-010 Ports out_valid (output, 1), out_ready (input, 1) and out_bit (output, 1): result handshake.
REQ-011 Port busy, output, 1: high while in LOAD.

Function
REQ-012 The FSM SHALL have two states: RUN (evaluate) and LOAD (serial reload).
REQ-013 In RUN, in_ready SHALL equal !out_valid || out_ready; in LOAD, in_ready SHALL be 0.
REQ-014 On an accepted input (in_valid && in_ready), the next cycle SHALL show out_bit = table[in_vec] and out_valid = 1; latency 1, throughput 1 per cycle.
REQ-015 While out_valid && !out_ready, out_bit and out_valid SHALL hold.
REQ-016 out_valid SHALL clear after a cycle with out_ready=1 and no new accept.
REQ-017 cfg_start in RUN SHALL enter LOAD next cycle; cfg_start in LOAD SHALL be ignored.
REQ-018 If cfg_start and an accept occur in the same cycle, that input SHALL be evaluated with the old table.
REQ-019 Pending output SHALL remain valid and drainable during LOAD.
REQ-020 In LOAD, each cfg_valid cycle SHALL shift cfg_bit into a shadow register, table index 0 first; cycles without cfg_valid SHALL stall the load.
REQ-021 The load bit counter SHALL be N_IN+1 bits wide.
REQ-022 After bit 2**N_IN-1, the shadow register SHALL be committed to the active table, cfg_done SHALL pulse for one cycle, and the FSM SHALL return to RUN on the following cycle.
REQ-023 The active table SHALL never change except on commit or reset.
REQ-024 cfg_err SHALL clear on an accepted cfg_start.

Reset
REQ-025 While rst_n=0, the block SHALL be in RUN with table=TT_DEFAULT, shadow=0, counter=0, out_valid=0, out_bit=0, cfg_done=0, cfg_err=0, busy=0.
REQ-026 in_ready SHALL be 1 during and after reset.
REQ-027 Reset mid-load SHALL discard the partial shadow register; no commit SHALL occur.

Configuration
REQ-028 With macro TT_LOGIC_ENGINE_PARITY_EN defined, LOAD SHALL accept one extra cfg_bit after the table bits, carrying even parity over the table.
REQ-029 With TT_LOGIC_ENGINE_PARITY_EN defined, a parity mismatch SHALL suppress the commit, set cfg_err, and still pulse cfg_done.
REQ-030 Without TT_LOGIC_ENGINE_PARITY_EN, no parity bit SHALL be taken and cfg_err SHALL be tied to 0.

Structure
REQ-031 Package tt_logic_pkg SHALL hold the state enum (RUN, LOAD) and a function tt_width(n) returning 2**n.
REQ-032 The serial shift register, counter and parity check SHALL form sub-module tt_shift_loader; the FSM and output register SHALL stay in the top module.

Verification (N_IN=4)
REQ-033 Reset release, then in_vec=5 and in_vec=4 back-to-back with out_ready=1 -> out_bit=1 then 0, one cycle after each accept, no bubbles.
REQ-034 out_ready=0 for 3 cycles after in_vec=9 -> out_bit=1 held, in_ready=0; on out_ready=1, the next input is accepted in the same cycle.
REQ-035 cfg_start, then 16 bits of 0x8001 with cfg_valid gaps -> cfg_done pulse; in_vec=15 -> 1, in_vec=5 -> 0; busy=1 only during LOAD.
REQ-036 cfg_start with a simultaneous accept of in_vec=6 -> out_bit=1 (old table); in_ready=0 until LOAD completes.
REQ-037 rst_n asserted after 7 load bits -> table=0x0760 (in_vec=8 -> 1); no cfg_done pulse.
REQ-038 With TT_LOGIC_ENGINE_PARITY_EN, table 0x0001 sent with parity bit 0 -> cfg_err=1, cfg_done pulses, table unchanged at 0x0760.
